// File: rtl/controlador_bases.sv
// Sequencer for the base-conversion / 7-segment path: holds the loaded value, rotates or follows
// the selected base, and blanks the displays briefly after every base change.
module controlador_bases #(
  parameter int PERIODO      = 50_000_000,
  parameter int BLANK_CICLOS = 4,
  parameter int LARGURA_CONT = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] valor_in,
  input  logic       carregar,
  input  logic       modo_auto,
  input  logic [1:0] base_manual,
  output logic [7:0] valor_binario,
  output logic [1:0] base_selecionada,
  output logic       apagar,
  output logic       valido,
  output logic       troca
);

  localparam int BW = (BLANK_CICLOS > 1) ? $clog2(BLANK_CICLOS) : 1;
  localparam logic [LARGURA_CONT-1:0] CONT_FIM = LARGURA_CONT'(PERIODO - 1);

  typedef enum logic [1:0] {OCIOSO, EXIBINDO, TROCA} estado_t;

  estado_t                 estado_q;
  logic [7:0]              valor_q;
  logic [1:0]              base_q;
  logic                    apagar_q;
  logic                    valido_q;
  logic                    troca_q;
  logic [LARGURA_CONT-1:0] cont_q;
  logic [BW-1:0]           blank_q;
  logic [1:0]              base_manual_map;

  function automatic logic [1:0] proxima_base(input logic [1:0] b);
    case (b)
      2'b00:   proxima_base = 2'b01;
      2'b01:   proxima_base = 2'b10;
      default: proxima_base = 2'b00;
    endcase
  endfunction

  // Code 11 is not a valid base; it selects decimal.
  always_comb begin
    base_manual_map = (base_manual == 2'b11) ? 2'b00 : base_manual;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      valor_q  <= '0;
      base_q   <= 2'b00;
      apagar_q <= 1'b1;
      valido_q <= 1'b0;
      troca_q  <= 1'b0;
      cont_q   <= '0;
      blank_q  <= '0;
    end else begin
      // NOTE: troca defaults low every cycle, so any set below is a single-cycle pulse.
      troca_q <= 1'b0;
      if (carregar) begin
        valor_q  <= valor_in;
        valido_q <= 1'b1;
        cont_q   <= '0;
        blank_q  <= '0;
        apagar_q <= 1'b0;
        estado_q <= EXIBINDO;
      end else begin
        case (estado_q)
          OCIOSO: begin
            apagar_q <= 1'b1;
            cont_q   <= '0;
            if (!modo_auto) base_q <= base_manual_map;
          end
          EXIBINDO: begin
            if (modo_auto) begin
              if (cont_q == CONT_FIM) begin
                cont_q  <= '0;
                base_q  <= proxima_base(base_q);
                troca_q <= 1'b1;
                if (BLANK_CICLOS > 0) begin
                  estado_q <= TROCA;
                  apagar_q <= 1'b1;
                  blank_q  <= '0;
                end
              end else begin
                cont_q <= cont_q + 1'b1;
              end
            end else begin
              cont_q <= '0;
              if (base_manual_map != base_q) begin
                base_q  <= base_manual_map;
                troca_q <= 1'b1;
                if (BLANK_CICLOS > 0) begin
                  estado_q <= TROCA;
                  apagar_q <= 1'b1;
                  blank_q  <= '0;
                end
              end
            end
          end
          TROCA: begin
            // A manual change inside the blank window restarts the window.
            if (!modo_auto && (base_manual_map != base_q)) begin
              base_q  <= base_manual_map;
              troca_q <= 1'b1;
              blank_q <= '0;
            end else if (int'(blank_q) == BLANK_CICLOS - 1) begin
              estado_q <= EXIBINDO;
              apagar_q <= 1'b0;
              cont_q   <= '0;
              blank_q  <= '0;
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          default: estado_q <= OCIOSO;
        endcase
      end
    end
  end

  assign valor_binario    = valor_q;
  assign base_selecionada = base_q;
  assign apagar           = apagar_q;
  assign valido           = valido_q;
  assign troca            = troca_q;

endmodule

// File: tb/tb_controlador_bases.sv
// Bench for controlador_bases: directed stimulus queues expected base changes; monitors pop and
// compare them whenever a DUT pulses troca. A second instance covers the no-blanking build.
module tb_controlador_bases;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, carregar, modo_auto;
  logic [7:0] valor_in;
  logic [1:0] base_manual;
  logic [7:0] valor_binario;
  logic [1:0] base_selecionada;
  logic       apagar, valido, troca;

  logic       reset_z, carregar_z, modo_auto_z;
  logic [7:0] valor_in_z;
  logic [1:0] base_manual_z;
  logic [7:0] valor_binario_z;
  logic [1:0] base_selecionada_z;
  logic       apagar_z, valido_z, troca_z;

  controlador_bases #(.PERIODO(8), .BLANK_CICLOS(2), .LARGURA_CONT(4)) dut (
    .clk(clk), .reset(reset), .valor_in(valor_in), .carregar(carregar),
    .modo_auto(modo_auto), .base_manual(base_manual), .valor_binario(valor_binario),
    .base_selecionada(base_selecionada), .apagar(apagar), .valido(valido), .troca(troca)
  );

  controlador_bases #(.PERIODO(8), .BLANK_CICLOS(0), .LARGURA_CONT(4)) dut_z (
    .clk(clk), .reset(reset_z), .valor_in(valor_in_z), .carregar(carregar_z),
    .modo_auto(modo_auto_z), .base_manual(base_manual_z), .valor_binario(valor_binario_z),
    .base_selecionada(base_selecionada_z), .apagar(apagar_z), .valido(valido_z), .troca(troca_z)
  );

  int edge_n = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) edge_n++;

  typedef struct {
    int         edge_no;
    logic [1:0] base;
    logic [7:0] valor;
    logic       apagar;
  } ev_t;

  ev_t sb[$];
  ev_t sb_z[$];

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nome, atual, esperado, edge_n);
    end
  endtask

  function automatic ev_t ev(input int e, input logic [1:0] b, input logic [7:0] v, input logic a);
    ev_t t;
    t.edge_no = e;
    t.base    = b;
    t.valor   = v;
    t.apagar  = a;
    return t;
  endfunction

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  task automatic esperar(input int e);
    while (edge_n < e) passo();
  endtask

  task automatic check_reset_vals(input string nome);
    check({nome, "_apagar"}, apagar, 1'b1);
    check({nome, "_valido"}, valido, 1'b0);
    check({nome, "_valor"}, valor_binario, 8'h00);
    check({nome, "_base"}, base_selecionada, 2'b00);
    check({nome, "_troca"}, troca, 1'b0);
  endtask

  ev_t m;
  always @(negedge clk) begin
    if (troca === 1'b1) begin
      if (sb.size() == 0) begin
        check("troca_spurious", troca, 1'b0);
      end else begin
        m = sb.pop_front();
        check("troca_edge", edge_n, m.edge_no);
        check("troca_base", base_selecionada, m.base);
        check("troca_valor", valor_binario, m.valor);
        check("troca_apagar", apagar, m.apagar);
      end
    end
  end

  ev_t m_z;
  always @(negedge clk) begin
    if (troca_z === 1'b1) begin
      if (sb_z.size() == 0) begin
        check("z_troca_spurious", troca_z, 1'b0);
      end else begin
        m_z = sb_z.pop_front();
        check("z_troca_edge", edge_n, m_z.edge_no);
        check("z_troca_base", base_selecionada_z, m_z.base);
        check("z_troca_valor", valor_binario_z, m_z.valor);
        check("z_troca_apagar", apagar_z, m_z.apagar);
      end
    end
  end

  int l, x, y, z, r, k;

  initial begin
    reset = 1'b1; carregar = 1'b0; modo_auto = 1'b0; valor_in = 8'h00; base_manual = 2'b00;
    reset_z = 1'b1; carregar_z = 1'b0; modo_auto_z = 1'b1; valor_in_z = 8'h00; base_manual_z = 2'b00;
    passo();
    passo();
    check_reset_vals("rst");

    // Idle after reset: nothing loaded, displays stay blanked, no troca.
    reset = 1'b0;
    repeat (10) passo();
    check_reset_vals("idle");

    // Automatic rotation with 2-cycle blanking.
    modo_auto = 1'b1; valor_in = 8'hB7; carregar = 1'b1;
    l = edge_n + 1;
    passo();
    carregar = 1'b0;
    check("load_valor", valor_binario, 8'hB7);
    check("load_valido", valido, 1'b1);
    check("load_apagar", apagar, 1'b0);
    check("load_base", base_selecionada, 2'b00);
    sb.push_back(ev(l + 8, 2'b01, 8'hB7, 1'b1));
    sb.push_back(ev(l + 18, 2'b10, 8'hB7, 1'b1));
    sb.push_back(ev(l + 28, 2'b00, 8'hB7, 1'b1));
    esperar(l + 7);
    check("auto_pre_base", base_selecionada, 2'b00);
    check("auto_pre_apagar", apagar, 1'b0);
    esperar(l + 8);
    check("auto_chg_base", base_selecionada, 2'b01);
    check("auto_blank0", apagar, 1'b1);
    esperar(l + 9);
    check("auto_blank1", apagar, 1'b1);
    esperar(l + 10);
    check("auto_unblank", apagar, 1'b0);
    esperar(l + 18);
    check("auto_base_oct", base_selecionada, 2'b10);
    esperar(l + 28);
    check("auto_base_dec", base_selecionada, 2'b00);

    // Manual mode: load during the blank window, then 00 -> 10 -> 11(=00).
    modo_auto = 1'b0; base_manual = 2'b00; valor_in = 8'h2A; carregar = 1'b1;
    passo();
    carregar = 1'b0;
    check("man_load_valor", valor_binario, 8'h2A);
    check("man_load_apagar", apagar, 1'b0);
    check("man_load_base", base_selecionada, 2'b00);
    passo();
    check("man_hold_base", base_selecionada, 2'b00);
    base_manual = 2'b10;
    x = edge_n + 1;
    sb.push_back(ev(x, 2'b10, 8'h2A, 1'b1));
    passo();
    check("man_base_oct", base_selecionada, 2'b10);
    check("man_blank0", apagar, 1'b1);
    passo();
    check("man_blank1", apagar, 1'b1);
    passo();
    check("man_unblank", apagar, 1'b0);
    base_manual = 2'b11;
    y = edge_n + 1;
    sb.push_back(ev(y, 2'b00, 8'h2A, 1'b1));
    passo();
    check("man_base_11", base_selecionada, 2'b00);
    esperar(y + 2);
    check("man_unblank2", apagar, 1'b0);

    // Load on the expiry cycle wins: no change, period restarts.
    z = edge_n;
    modo_auto = 1'b1;
    esperar(z + 7);
    valor_in = 8'h55; carregar = 1'b1;
    passo();
    carregar = 1'b0;
    check("exp_load_valor", valor_binario, 8'h55);
    check("exp_load_base", base_selecionada, 2'b00);
    check("exp_load_apagar", apagar, 1'b0);
    sb.push_back(ev(z + 16, 2'b01, 8'h55, 1'b1));
    esperar(z + 15);
    check("exp_pre_base", base_selecionada, 2'b00);
    esperar(z + 16);
    check("exp_chg_base", base_selecionada, 2'b01);
    check("exp_chg_apagar", apagar, 1'b1);

    // Reset in the middle of the blank window, then resume from base 00.
    reset = 1'b1;
    passo();
    check_reset_vals("midrst");
    reset = 1'b0; valor_in = 8'h3C; carregar = 1'b1;
    r = edge_n + 1;
    passo();
    carregar = 1'b0;
    check("res_valor", valor_binario, 8'h3C);
    check("res_valido", valido, 1'b1);
    check("res_base", base_selecionada, 2'b00);
    sb.push_back(ev(r + 8, 2'b01, 8'h3C, 1'b1));
    esperar(r + 8);
    check("res_chg_base", base_selecionada, 2'b01);
    reset = 1'b1;
    passo();

    // No-blanking instance: rotation every 8 edges, apagar stays low.
    reset_z = 1'b0;
    passo();
    check("z_idle_apagar", apagar_z, 1'b1);
    valor_in_z = 8'h81; carregar_z = 1'b1;
    k = edge_n + 1;
    passo();
    carregar_z = 1'b0;
    check("z_load_valor", valor_binario_z, 8'h81);
    check("z_load_apagar", apagar_z, 1'b0);
    sb_z.push_back(ev(k + 8, 2'b01, 8'h81, 1'b0));
    sb_z.push_back(ev(k + 16, 2'b10, 8'h81, 1'b0));
    sb_z.push_back(ev(k + 24, 2'b00, 8'h81, 1'b0));
    esperar(k + 8);
    check("z_base_hex", base_selecionada_z, 2'b01);
    check("z_apagar_chg", apagar_z, 1'b0);
    esperar(k + 9);
    check("z_apagar_after", apagar_z, 1'b0);
    esperar(k + 16);
    check("z_base_oct", base_selecionada_z, 2'b10);
    esperar(k + 24);
    check("z_base_dec", base_selecionada_z, 2'b00);
    reset_z = 1'b1;
    passo();
    passo();

    check("sb_pending", sb.size(), 0);
    check("z_sb_pending", sb_z.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
